// File: rtl/int_to_fp_if.sv
// Valid/ready bundle between an integer producer, the int_to_fp converter
// and the floating-point operand consumer downstream.
interface int_to_fp_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [3:0]  exp_out;
  logic [7:0]  frac_out;
  logic        ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, frac_out, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sign_out, exp_out, frac_out, ovf
  );
endinterface

// File: rtl/int_to_fp.sv
// Serial int16 -> (sign, exp4, frac8) converter, one normalization shift per clock.
// Define INT_TO_FP_ROUND_EN for round-to-nearest (ties away); otherwise truncate.
module int_to_fp (
  input  logic         clk,
  input  logic         reset,
  int_to_fp_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        s_q, s_d;
  logic [15:0] m_q, m_d;
  logic [3:0]  e_q, e_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        sign_q, sign_d;
  logic [3:0]  exp_q, exp_d;
  logic [7:0]  frac_q, frac_d;
  logic        ovf_q, ovf_d;

`ifdef INT_TO_FP_ROUND_EN
  logic [8:0]  frac_inc;
  assign frac_inc = {1'b0, m_q[14:7]} + 9'd1;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    m_d     = m_q;
    e_d     = e_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.in_data[15];
          // Unsigned magnitude: -32768 lands on m[15] and is caught as saturation.
          m_d     = bus.in_data[15] ? (16'd0 - bus.in_data) : bus.in_data;
          e_d     = (bus.in_data == 16'd0) ? 4'd0 : 4'd15;
          state_d = NORM;
        end
      end

      NORM: begin
        if (m_q[15]) begin
          sign_d  = s_q;
          exp_d   = 4'd15;
          frac_d  = 8'd255;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (m_q[14] || (e_q == 4'd0)) begin
          sign_d  = s_q & (m_q != 16'd0);
          exp_d   = e_q;
          frac_d  = m_q[14:7];
          ovf_d   = 1'b0;
`ifdef INT_TO_FP_ROUND_EN
          if (m_q[6]) begin
            if (!frac_inc[8]) begin
              frac_d = frac_inc[7:0];
            end else if (e_q == 4'd15) begin
              frac_d = 8'd255;
              ovf_d  = 1'b1;
            end else begin
              frac_d = 8'd128;
              exp_d  = e_q + 4'd1;
            end
          end
`endif
          state_d = DONE;
        end else begin
          m_d = {m_q[14:0], 1'b0};
          e_d = e_q - 4'd1;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so both stay pure flop outputs.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values of one another.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      m_q         <= 16'd0;
      e_q         <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 4'd0;
      frac_q      <= 8'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      e_q         <= e_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sign_out  = sign_q;
  assign bus.exp_out   = exp_q;
  assign bus.frac_out  = frac_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed corner values plus random words,
// compared against an arithmetic model of the number format.
module tb_int_to_fp;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  int_to_fp_if bus ();

  int_to_fp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // value = (-1)^s * f * 2^(e-8) with f in [128,255]; exponent equals bit length.
  task automatic model(input int v, output int s, output int e, output int f,
                       output int o, output int lat);
    int a;
    int len;
    a = (v < 0) ? -v : v;
    s = 0; e = 0; f = 0; o = 0; lat = 1;
    if (a == 0) return;
    s = (v < 0) ? 1 : 0;
    if (a == 32768) begin
      e = 15; f = 255; o = 1;
      return;
    end
    len = 0;
    while ((a >> len) != 0) len++;
    e   = len;
    lat = 16 - len;
    f   = (len >= 8) ? (a >> (len - 8)) : (a << (8 - len));
`ifdef INT_TO_FP_ROUND_EN
    if (len >= 9 && ((a >> (len - 9)) & 1) == 1) begin
      f++;
      if (f == 256) begin
        if (e == 15) begin
          f = 255; o = 1;
        end else begin
          f = 128; e++;
        end
      end
    end
`endif
  endtask

  task automatic convert(input int v, input int hold);
    int s, e, f, o, lat, cnt;
    string t;
    t = $sformatf("v=%0d", v);
    model(v, s, e, f, o, lat);

    cnt = 0;
    while (!bus.in_ready && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    check({t, " in_ready"}, int'(bus.in_ready), 1);

    bus.in_data  = v[15:0];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hDEAD;

    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      check({t, " in_ready busy"}, int'(bus.in_ready), 0);
      @(posedge clk); #1; cnt++;
    end
    check({t, " latency"}, cnt, lat);
    check({t, " sign"}, int'(bus.sign_out), s);
    check({t, " exp"},  int'(bus.exp_out), e);
    check({t, " frac"}, int'(bus.frac_out), f);
    check({t, " ovf"},  int'(bus.ovf), o);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({t, " hold valid"}, int'(bus.out_valid), 1);
      check({t, " hold in_ready"}, int'(bus.in_ready), 0);
      check({t, " hold frac"}, int'(bus.frac_out), f);
      check({t, " hold exp"}, int'(bus.exp_out), e);
    end

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({t, " drained"}, int'(bus.out_valid), 0);
    check({t, " ready again"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int vals[$];
    int cnt;
    n_checks = 0;
    n_pass   = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'd0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #12;
    check("rst in_ready",  int'(bus.in_ready), 1);
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst sign",      int'(bus.sign_out), 0);
    check("rst exp",       int'(bus.exp_out), 0);
    check("rst frac",      int'(bus.frac_out), 0);
    check("rst ovf",       int'(bus.ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    vals = '{100, 1023, -32768, 0, -1, 1, 32767, -32767, 255, 256, 511, -128, 127, 16384};
    foreach (vals[i]) convert(vals[i], (i == 0) ? 5 : 0);

    for (int i = 0; i < 150; i++) begin
      logic signed [15:0] r;
      r = 16'($urandom);
      if (i % 4 == 0) r = r >>> $urandom_range(0, 14);
      convert(int'(r), $urandom_range(0, 2));
    end

    // Reset in the middle of normalization drops the word in flight.
    bus.in_data  = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid rst in_ready", int'(bus.in_ready), 1);
    check("mid rst out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    check("mid rst no output", cnt, 0);
    check("mid rst idle", int'(bus.in_ready), 1);

    convert(-1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_to_fp.md
# int_to_fp

Sequential converter that turns a signed 16-bit two's-complement integer into the team's 13-bit floating-point operand format (sign, 4-bit exponent, 8-bit normalized fraction). It sits directly upstream of the floating-point adder and produces the `sign`/`exp`/`frac` operand triple that the adder consumes. Normalization is serial, one bit per clock. Transfers on both sides use a valid/ready handshake.

## Interface
Parameters: none. Widths are fixed by the number format.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  converter can accept a word; high only in IDLE
- `in_data`  in  16  signed integer to convert
- `out_valid`  out  1  result registers hold a valid operand
- `out_ready`  in  1  consumer accepts the result
- `sign_out`  out  1  result sign
- `exp_out`  out  4  result exponent
- `frac_out`  out  8  result fraction; bit 7 is set for every nonzero result
- `ovf`  out  1  result was saturated; valid while `out_valid` is high

## Operation
- Number format: value = (−1)^sign × frac × 2^(exp−8). Zero is encoded as sign 0, exp 0, frac 0.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: `s` ← `in_data[15]`; `m[15:0]` ← |`in_data`| (unsigned, so −32768 gives `m[15]` = 1).
  - `e` ← 0 if `m` == 0, otherwise 15.
  - Go to NORM.
- **NORM** (`in_ready` = 0, `out_valid` = 0). Each cycle:
  - If `m[15]` is set: saturate. exp = 15, frac = 255, `ovf` = 1. Go to DONE.
  - Else if `m[14] | (e == 0)`: finish.
    - frac = `m[14:7]`, exp = `e`, sign = `s & (m != 0)`.
    - Apply rounding (see Configuration).
    - Go to DONE.
  - Else: `m` ← `m << 1`, `e` ← `e − 1`.
- Number of shift cycles S = 15 − L, where L is the bit length of |`in_data`| (1..15). S = 0 for zero and for saturation.
- **DONE**
  - `out_valid` = 1. Outputs are stable while `out_valid & ~out_ready`.
  - On `out_ready`: go to IDLE, `out_valid` ← 0.
  - `in_ready` returns high the cycle after the handshake. There is no bypass.
- Truncated bits are `m[6:0]`; the round bit is `m[6]`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `sign_out` 0, `exp_out` 0, `frac_out` 0, `ovf` 0.
- `reset` asserted in any state aborts the conversion in flight. The word in flight is dropped, not output.
- Latency from the accept edge to `out_valid` high is S+1 cycles:
  - 1 cycle for zero and for −32768.
  - 15 cycles for ±1.
- Minimum spacing between accepted inputs is S+3 cycles when `out_ready` is held high.
- `in_valid` is ignored outside IDLE. Upstream must hold `in_data` until the handshake completes.
- All outputs are registered. No combinational path from `out_ready` or `in_valid` to any output.

## Configuration
- `INT_TO_FP_ROUND_EN` defined: round to nearest, ties away from zero on magnitude.
  - If `m[6]` = 1, frac ← frac + 1.
  - If frac carries out: frac = 128 and exp + 1.
  - If exp was 15: saturate to exp 15, frac 255, `ovf` = 1.
- Undefined: truncate. `m[6:0]` is discarded and rounding never sets `ovf`.

## Test plan
- `in_data` = 100 → sign 0, exp 7, frac 200, `ovf` 0; `out_valid` 9 cycles after accept (S = 8).
- `in_data` = 1023 → with ROUND_EN: exp 11, frac 128. Without: exp 10, frac 255.
- `in_data` = −32768 → sign 1, exp 15, frac 255, `ovf` 1, latency 1.
- `in_data` = 0 → sign 0, exp 0, frac 0, latency 1.
- `in_data` = −1 → sign 1, exp 1, frac 128, latency 15.
- `in_data` = 32767 → with ROUND_EN: exp 15, frac 255, `ovf` 1. Without: exp 15, frac 255, `ovf` 0.
- Backpressure: hold `out_ready` low for 5 cycles in DONE → outputs stable and `in_ready` stays 0. Pulse `reset` mid-NORM → `out_valid` never asserts and `in_ready` = 1 immediately.
